// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: bit timing constants and FSM state encoding for the 8N1 receiver
package uart_receiver_pkg;
   localparam int CLKS_PER_BIT = 279;
   localparam int HALF_BIT     = 139;
   localparam logic [8:0] BIT_LAST  = 9'(CLKS_PER_BIT - 1);
   localparam logic [8:0] HALF_LAST = 9'(HALF_BIT - 1);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_e;
endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// uart_receiver_sync_2ff: two-flop synchroniser for the asynchronous serial line, resets to idle-high
module uart_receiver_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [1:0] sync_q;
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], d};
   end
   assign q = sync_q[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with mid-bit start validation, centre sampling and stop-bit framing check
module uart_receiver
   import uart_receiver_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   output logic [7:0] data_rx,
   output logic       valid,
   output logic       frame_err,
   output logic       busy,
   output logic [2:0] state,
   output logic [8:0] counter
);
   logic       din_s;
   state_e     state_q;
   logic [8:0] counter_q;
   logic [2:0] index_q;
   logic [7:0] shift_q, data_rx_q;
   logic       valid_q, frame_err_q, busy_q;

   uart_receiver_sync_2ff u_sync (.clk(clk), .rst(rst), .d(din), .q(din_s));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         counter_q   <= '0;
         index_q     <= '0;
         shift_q     <= '0;
         data_rx_q   <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               counter_q <= '0;
               index_q   <= '0;
               if (!din_s) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               counter_q <= (counter_q == HALF_LAST) ? '0 : counter_q + 9'd1;
               if (counter_q == HALF_LAST) begin
                  state_q <= din_s ? IDLE : DATA;
                  busy_q  <= !din_s;
               end
            end
            DATA: begin
               counter_q <= (counter_q == BIT_LAST) ? '0 : counter_q + 9'd1;
               if (counter_q == BIT_LAST) begin
                  shift_q[index_q] <= din_s;
                  if (index_q == 3'd7) state_q <= STOP;
                  else                 index_q <= index_q + 3'd1;
               end
            end
            STOP: begin
               counter_q <= (counter_q == BIT_LAST) ? '0 : counter_q + 9'd1;
               if (counter_q == BIT_LAST) begin
                  // a low stop bit parks in BREAK so a held-low line reports only once
                  if (din_s) begin
                     data_rx_q <= shift_q;
                     valid_q   <= 1'b1;
                     state_q   <= IDLE;
                     busy_q    <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (din_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_rx   = data_rx_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
   assign state     = state_q;
   assign counter   = counter_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed scenario bench driving 8N1 frames into uart_receiver
module tb_uart_receiver;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b1;
   logic [7:0] data_rx;
   logic       valid, frame_err, busy;
   logic [2:0] state;
   logic [8:0] counter;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int vcnt = 0, fcnt = 0, both = 0;
   int vcyc = 0, fcyc = 0;
   logic [7:0] vdata [$];

   uart_receiver dut (
      .clk(clk), .rst(rst), .din(din), .data_rx(data_rx), .valid(valid),
      .frame_err(frame_err), .busy(busy), .state(state), .counter(counter)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // a pulse seen here with cyc==N was set at edge N and is first sampled at edge N+1
   always @(negedge clk) begin
      if (valid) begin
         vcnt++;
         vcyc = cyc;
         vdata.push_back(data_rx);
      end
      if (frame_err) begin
         fcnt++;
         fcyc = cyc;
      end
      if (valid && frame_err) both++;
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // transmitter model; t returns the first edge that samples the start bit low
   task automatic send_frame(input logic [7:0] b, input logic stop, output int t);
      t = cyc + 1;
      din = 1'b0;
      wait_cycles(279);
      for (int i = 0; i < 8; i++) begin
         din = b[i];
         wait_cycles(279);
      end
      din = stop;
      wait_cycles(279);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      din = 1'b1;
      wait_cycles(3);
      rst = 1'b0;
      checks++; if (state !== 3'd0)     begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (counter !== 9'd0)   begin errors++; $display("FAIL reset_counter: got %0d expected 0", counter); end
      checks++; if (data_rx !== 8'h00)  begin errors++; $display("FAIL reset_data: got %h expected 00", data_rx); end
      checks++; if ({valid, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {valid, frame_err, busy}); end
   endtask

   task automatic test_idle;
      int bad = 0;
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      din = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         wait_cycles(1);
         if (busy !== 1'b0 || valid !== 1'b0 || counter !== 9'd0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_loopback;
      int t;
      int v0 = vcnt, f0 = fcnt;
      send_frame(8'hA5, 1'b1, t);
      wait_cycles(20);
      checks++; if (vcnt - v0 !== 1)    begin errors++; $display("FAIL loop_pulses: got %0d expected 1", vcnt - v0); end
      checks++; if (data_rx !== 8'hA5)  begin errors++; $display("FAIL loop_data: got %h expected a5", data_rx); end
      checks++; if (vcyc !== t + 2652)  begin errors++; $display("FAIL loop_latency: got %0d expected %0d", vcyc - t, 2652); end
      checks++; if (fcnt - f0 !== 0)    begin errors++; $display("FAIL loop_ferr: got %0d expected 0", fcnt - f0); end
   endtask

   task automatic test_back_to_back;
      int t;
      int v0 = vcnt, f0 = fcnt;
      vdata.delete();
      send_frame(8'h00, 1'b1, t);
      send_frame(8'hFF, 1'b1, t);
      wait_cycles(20);
      checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", vcnt - v0); end
      checks++; if (vdata.size() != 2 || vdata[0] !== 8'h00 || vdata[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %0d bytes expected 00 ff", vdata.size()); end
      checks++; if (fcnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", fcnt - f0); end
   endtask

   task automatic test_glitch;
      int t;
      int v0 = vcnt;
      t = cyc + 1;
      din = 1'b0;
      wait_cycles(50);
      din = 1'b1;
      wait_cycles(t + 140 - cyc);
      checks++; if (state !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL glitch_start: got state %0d busy %b expected 1 1", state, busy); end
      wait_cycles(1);
      checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got state %0d busy %b expected 0 0", state, busy); end
      wait_cycles(300);
      checks++; if (vcnt - v0 !== 0)   begin errors++; $display("FAIL glitch_valid: got %0d expected 0", vcnt - v0); end
      checks++; if (data_rx !== 8'hFF) begin errors++; $display("FAIL glitch_data: got %h expected ff", data_rx); end
   endtask

   task automatic test_frame_err;
      int t;
      int v0 = vcnt, f0 = fcnt;
      send_frame(8'h3C, 1'b0, t);
      wait_cycles(1000);
      checks++; if (fcnt - f0 !== 1)    begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fcnt - f0); end
      checks++; if (fcyc !== t + 2652)  begin errors++; $display("FAIL ferr_latency: got %0d expected %0d", fcyc - t, 2652); end
      checks++; if (vcnt - v0 !== 0)    begin errors++; $display("FAIL ferr_valid: got %0d expected 0", vcnt - v0); end
      checks++; if (data_rx !== 8'hFF)  begin errors++; $display("FAIL ferr_data: got %h expected ff", data_rx); end
      checks++; if (state !== 3'd4 || busy !== 1'b1) begin errors++; $display("FAIL ferr_break: got state %0d busy %b expected 4 1", state, busy); end
      din = 1'b1;
      wait_cycles(2);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_hold: got %b expected 1", busy); end
      wait_cycles(1);
      checks++; if (busy !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL ferr_release: got state %0d busy %b expected 0 0", state, busy); end
   endtask

   task automatic test_reset_midframe;
      int t;
      int v0, f0;
      logic [7:0] b = 8'h5A;
      din = 1'b0;
      wait_cycles(279);
      for (int i = 0; i < 4; i++) begin
         din = b[i];
         wait_cycles(279);
      end
      din = b[4];
      wait_cycles(100);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      din = 1'b1;
      checks++; if (state !== 3'd0 || counter !== 9'd0) begin errors++; $display("FAIL mid_rst_state: got state %0d counter %0d expected 0 0", state, counter); end
      checks++; if (data_rx !== 8'h00 || {valid, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL mid_rst_out: got data %h flags %b expected 00 000", data_rx, {valid, frame_err, busy}); end
      v0 = vcnt;
      f0 = fcnt;
      wait_cycles(3000);
      checks++; if (vcnt - v0 !== 0 || fcnt - f0 !== 0) begin errors++; $display("FAIL mid_rst_quiet: got %0d valid %0d ferr expected 0 0", vcnt - v0, fcnt - f0); end
      send_frame(8'h81, 1'b1, t);
      wait_cycles(20);
      checks++; if (vcnt - v0 !== 1 || data_rx !== 8'h81) begin errors++; $display("FAIL mid_rst_next: got %0d pulses data %h expected 1 81", vcnt - v0, data_rx); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_loopback();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_midframe();
      checks++; if (both !== 0) begin errors++; $display("FAIL overlap: got %0d cycles with valid and frame_err expected 0", both); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
